// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: size encodings, sequencer states and transfer helpers
package mem_ctrl_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, DONE} state_t;

    // 2'b11 falls through to a word transfer
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? addr[0] : addr != 2'b00;
    endfunction
endpackage

// File: rtl/mem_port_arb.sv
// mem_port_arb: two-port grant that alternates priority on a tie
module mem_port_arb (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic if_req,
    input  logic d_req,
    output logic gnt_valid,
    output logic gnt_d
);
    logic last_d;
    assign gnt_valid = en & (if_req | d_req);
    assign gnt_d = d_req & (~if_req | ~last_d);
    always_ff @(posedge clk) begin
        if (!reset)
            last_d <= 1'b0;
        else if (gnt_valid)
            last_d <= gnt_d;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch/data ports onto a byte-wide synchronous RAM,
// sequencing word/half/byte transfers as big-endian byte accesses.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              misalign,
    output logic [ADDR_W-1:0] mar,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);
    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH must equal 2**ADDR_W");
    end

    state_t state, nxt;
    logic gnt_valid, gnt_d, gnt_d_r, mis_r, sel_we, sel_mis;
    logic [1:0] cnt, last_idx, sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [23:0] rsh;
    logic [31:0] wsh;

    mem_port_arb u_arb (
        .clk(clk), .reset(reset), .en(state == IDLE),
        .if_req(if_req), .d_req(d_req), .gnt_valid(gnt_valid), .gnt_d(gnt_d)
    );

    assign sel_size = gnt_d ? d_size : SZ_WORD;
    assign sel_addr = gnt_d ? d_addr : if_addr;
    assign sel_we   = gnt_d & d_we;
    assign sel_mis  = is_misaligned(sel_size, sel_addr[1:0]);

    assign busy      = state != IDLE;
    assign ram_we    = state == WR && reset;
    assign ram_wdata = wsh[31:24];
    assign if_ack    = state == DONE && !gnt_d_r;
    assign d_ack     = state == DONE && gnt_d_r;
    assign misalign  = state == DONE && mis_r;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !gnt_valid ? IDLE : sel_mis ? DONE : sel_we ? WR : RD;
            RD:      nxt = cnt == last_idx ? RD_LAST : RD;
            RD_LAST: nxt = DONE;
            WR:      nxt = cnt == last_idx ? DONE : WR;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            gnt_d_r  <= 1'b0;
            mis_r    <= 1'b0;
            cnt      <= '0;
            last_idx <= '0;
            mar      <= '0;
            rsh      <= '0;
            wsh      <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (gnt_valid) begin
                    gnt_d_r  <= gnt_d;
                    mis_r    <= sel_mis;
                    last_idx <= 2'(nbytes(sel_size) - 3'd1);
                    cnt      <= '0;
                    rsh      <= '0;
                    if (!sel_mis)
                        mar <= sel_addr;
                    // store data is left-justified so the MSB-first byte is always wsh[31:24]
                    if (sel_we && !sel_mis)
                        wsh <= sel_size == SZ_BYTE ? {d_wdata[7:0], 24'b0} :
                               sel_size == SZ_HALF ? {d_wdata[15:0], 16'b0} : d_wdata;
                end
                RD: begin
                    if (cnt != 2'd0)
                        rsh <= {rsh[15:0], ram_rdata};
                    if (cnt != last_idx) begin
                        mar <= mar + ADDR_W'(1);
                        cnt <= cnt + 2'd1;
                    end
                end
                RD_LAST: begin
                    if (gnt_d_r)
                        d_rdata <= {rsh, ram_rdata};
                    else
                        if_rdata <= {rsh, ram_rdata};
                end
                WR: if (cnt != last_idx) begin
                    mar <= mar + ADDR_W'(1);
                    cnt <= cnt + 2'd1;
                    wsh <= {wsh[23:0], 8'b0};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for the memory sequencer with a synchronous RAM model
module tb_mem_access_ctrl;
    logic clk = 0, reset = 0;
    logic if_req = 0, d_req = 0, d_we = 0;
    logic [8:0] if_addr = '0, d_addr = '0, mar;
    logic [1:0] d_size = '0;
    logic [31:0] d_wdata = '0, if_rdata, d_rdata;
    logic if_ack, d_ack, misalign, ram_we, busy;
    logic [7:0] ram_wdata, ram_rdata = '0;
    logic [7:0] mem [512];
    logic [7:0] ref_mem [512];
    logic [31:0] exp_if = '0, exp_d = '0;
    int n_chk = 0, n_fail = 0, n_ack = 0;

    typedef struct {bit dport; logic [31:0] data; bit mis;} sb_t;
    sb_t sb[$];
    sb_t mon_e;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .misalign(misalign), .mar(mar),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[mar] <= ram_wdata;
        ram_rdata <= mem[mar];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [1:0] sz, input logic [8:0] a);
        return sz == 2'b00 ? 1'b0 : sz == 2'b01 ? a[0] : a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [1:0] sz, input logic [8:0] a);
        logic [31:0] r = '0;
        for (int k = 0; k < nb(sz); k++) r = {r[23:0], ref_mem[9'(a + 9'(k))]};
        return r;
    endfunction

    task automatic ref_write(input logic [1:0] sz, input logic [8:0] a, input logic [31:0] wd);
        int n = nb(sz);
        for (int k = 0; k < n; k++) ref_mem[9'(a + 9'(k))] = 8'(wd >> (8 * (n - 1 - k)));
    endtask

    always @(negedge clk) begin
        if (reset && (if_ack || d_ack)) begin
            n_ack++;
            check("single_ack", 32'(if_ack & d_ack), 32'd0);
            if (sb.size() == 0)
                check("unexpected_ack", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                check("ack_port", 32'(d_ack), 32'(mon_e.dport));
                check("rdata", d_ack ? d_rdata : if_rdata, mon_e.data);
                check("misalign", 32'(misalign), 32'(mon_e.mis));
            end
        end
    end

    task automatic do_req(input string tag, input bit dport, input bit we, input logic [1:0] sz,
                          input logic [8:0] a, input logic [31:0] wd);
        logic [1:0] esz = dport ? sz : 2'b10;
        int n = nb(esz);
        bit mis = misal(esz, a);
        bit ewe = dport & we;
        int exp_cyc = mis ? 1 : ewe ? n + 1 : n + 2;
        int cyc = 0;
        bit done = 0;
        logic [8:0] mar0;
        sb_t e;
        if (ewe && !mis) ref_write(esz, a, wd);
        if (!mis && !ewe) begin
            if (dport) exp_d = ref_rd(esz, a);
            else exp_if = ref_rd(esz, a);
        end
        e.dport = dport;
        e.mis = mis;
        e.data = dport ? exp_d : exp_if;
        sb.push_back(e);
        @(posedge clk); #1;
        mar0 = mar;
        if (dport) begin
            d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1; if_addr = a;
        end
        while (!done && cyc < 20) begin
            @(negedge clk);
            if (cyc == 1) begin
                d_addr = a ^ 9'h155; d_wdata = ~wd; d_size = ~sz; if_addr = a ^ 9'h0AA;
            end
            if (!mis && cyc >= 1 && cyc <= n) begin
                check({tag, "_mar"}, 32'(mar), 32'(9'(a + 9'(cyc - 1))));
                check({tag, "_ram_we"}, 32'(ram_we), 32'(ewe));
            end
            if (mis && cyc == 1) begin
                check({tag, "_mar_hold"}, 32'(mar), 32'(mar0));
                check({tag, "_no_we"}, 32'(ram_we), 32'd0);
            end
            if (dport ? d_ack : if_ack) done = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, "_ack_cycle"}, 32'(cyc), 32'(exp_cyc));
        @(posedge clk); #1;
        if_req = 0; d_req = 0;
    endtask

    initial begin
        sb_t e;
        int cyc;
        for (int i = 0; i < 512; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        mem[9'h010] = 8'h8C; mem[9'h011] = 8'h22; mem[9'h012] = 8'h00; mem[9'h013] = 8'h04;
        mem[9'h020] = 8'hF0; mem[9'h021] = 8'h0F;
        ref_mem[9'h010] = 8'h8C; ref_mem[9'h011] = 8'h22; ref_mem[9'h012] = 8'h00; ref_mem[9'h013] = 8'h04;
        ref_mem[9'h020] = 8'hF0; ref_mem[9'h021] = 8'h0F;

        // both ports held high across reset: data wins the first tie, then they alternate
        if_req = 1; if_addr = 9'h010;
        d_req = 1; d_we = 0; d_size = 2'b01; d_addr = 9'h020;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mar", 32'(mar), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_acks", 32'({if_ack, d_ack, misalign}), 32'd0);
        exp_d = ref_rd(2'b01, 9'h020);
        exp_if = ref_rd(2'b10, 9'h010);
        for (int i = 0; i < 2; i++) begin
            e.mis = 0;
            e.dport = 1; e.data = exp_d; sb.push_back(e);
            e.dport = 0; e.data = exp_if; sb.push_back(e);
        end
        @(posedge clk); #1;
        reset = 1;
        cyc = 0;
        while (n_ack < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        if_req = 0; d_req = 0;
        check("contention_acks", 32'(n_ack), 32'd4);
        @(negedge clk);
        check("contention_idle", 32'(busy), 32'd0);

        do_req("fetch", 0, 0, 2'b10, 9'h010, 32'h0);
        do_req("st_word", 1, 1, 2'b10, 9'h1FC, 32'hDEADBEEF);
        do_req("ld_half", 1, 0, 2'b01, 9'h020, 32'h0);
        do_req("ld_byte", 1, 0, 2'b00, 9'h021, 32'h0);
        do_req("mis_word", 1, 0, 2'b10, 9'h022, 32'h0);
        do_req("mis_half_st", 1, 1, 2'b01, 9'h031, 32'h0000FFFF);
        do_req("st_byte", 1, 1, 2'b00, 9'h030, 32'h123456AB);
        do_req("st_half", 1, 1, 2'b01, 9'h032, 32'h7777CD12);
        do_req("ld_word", 1, 0, 2'b10, 9'h030, 32'h0);
        do_req("fetch_top", 0, 0, 2'b10, 9'h1FC, 32'h0);
        do_req("ld_size3", 1, 0, 2'b11, 9'h1FC, 32'h0);
        check("ram_1fc", 32'(mem[9'h1FC]), 32'h0DE);
        check("ram_1fd", 32'(mem[9'h1FD]), 32'h0AD);
        check("ram_1fe", 32'(mem[9'h1FE]), 32'h0BE);
        check("ram_1ff", 32'(mem[9'h1FF]), 32'h0EF);
        check("ram_031", 32'(mem[9'h031]), 32'h000);

        // reset pulled low in cycle 2 of a word store
        ref_mem[9'h040] = 8'h11;
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 9'h040; d_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0; d_req = 0;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ram_we", 32'(ram_we), 32'd0);
        check("rstmid_mar", 32'(mar), 32'd0);
        check("rstmid_d_rdata", d_rdata, 32'd0);
        check("rstmid_ram_040", 32'(mem[9'h040]), 32'h011);
        check("rstmid_ram_041", 32'(mem[9'h041]), 32'h000);
        check("rstmid_ram_043", 32'(mem[9'h043]), 32'h000);
        exp_d = '0; exp_if = '0;
        do_req("ld_after_rst", 1, 0, 2'b10, 9'h040, 32'h0);
        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
